wb_master_port: RTL and testbench

//  Wishbone initiator: turns single-beat read/write requests from a CPU-side client into

---
 rtl/wb_master_port_if.sv | 35 +++
 rtl/wb_master_port.sv | 131 +++++++++++++
 tb/tb_wb_master_port.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_master_port_if.sv
// Wishbone classic bus bundle shared by wb_master_port and its slaves.
// Signal names follow the local bus naming: address/data_in/write_enable are
// driven by the initiator, data_out/ack come back from the slave.
interface wishbone_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] address;
  logic                  cycle;
  logic                  strobe;
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  ack;

  modport master (
    output address,
    output cycle,
    output strobe,
    output write_enable,
    output data_in,
    input  data_out,
    input  ack
  );

  modport slave (
    input  address,
    input  cycle,
    input  strobe,
    input  write_enable,
    input  data_in,
    output data_out,
    output ack
  );
endinterface

// File: rtl/wb_master_port.sv
// Wishbone classic initiator: accepts one single-beat read/write request at a
// time from a CPU-side client, runs it as a Wishbone cycle and returns read
// data/status on a valid/ready response channel. Misaligned requests are
// answered with an error and never reach the bus.
// Optional ack watchdog: define WB_MASTER_TIMEOUT_EN to abort a bus cycle after
// TIMEOUT_CYCLES cycles without ack (response carries resp_error=1).
module wb_master_port #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  wishbone_if.master            wishbone
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] address_q;
  logic [DATA_WIDTH-1:0] data_in_q;
  logic                  write_enable_q;
  logic                  cycle_q;
  logic                  strobe_q;

  // The watchdog counter needs room to reach TIMEOUT_CYCLES-1.
  if (TIMEOUT_CYCLES < 2) begin : gen_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] timeout_cnt_q;
`endif

  // Ready only in IDLE and never while reset is held low.
  assign req_ready = (state_q == StIdle) && reset;

  assign wishbone.address      = address_q;
  assign wishbone.data_in      = data_in_q;
  assign wishbone.write_enable = write_enable_q;
  assign wishbone.cycle        = cycle_q;
  assign wishbone.strobe       = strobe_q;

  // Transaction FSM with all bus and response outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= StIdle;
      address_q      <= '0;
      data_in_q      <= '0;
      write_enable_q <= 1'b0;
      cycle_q        <= 1'b0;
      strobe_q       <= 1'b0;
      resp_valid     <= 1'b0;
      resp_error     <= 1'b0;
      resp_rdata     <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      timeout_cnt_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (req_addr[1:0] != 2'b00) begin
              // Misaligned: answer directly, no bus cycle.
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
              state_q    <= StResp;
            end else begin
              address_q      <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              data_in_q      <= req_wdata;
              write_enable_q <= req_write;
              cycle_q        <= 1'b1;
              strobe_q       <= 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
              timeout_cnt_q  <= '0;
`endif
              state_q        <= StBus;
            end
          end
        end
        StBus: begin
          // Ack is checked first so an ack on the expiry edge still completes normally.
          if (wishbone.ack) begin
            cycle_q        <= 1'b0;
            strobe_q       <= 1'b0;
            write_enable_q <= 1'b0;
            resp_rdata     <= write_enable_q ? '0 : wishbone.data_out;
            resp_error     <= 1'b0;
            resp_valid     <= 1'b1;
            state_q        <= StResp;
          end
`ifdef WB_MASTER_TIMEOUT_EN
          else if (timeout_cnt_q == CntMax) begin
            cycle_q        <= 1'b0;
            strobe_q       <= 1'b0;
            write_enable_q <= 1'b0;
            resp_rdata     <= '0;
            resp_error     <= 1'b1;
            resp_valid     <= 1'b1;
            state_q        <= StResp;
          end else begin
            timeout_cnt_q <= timeout_cnt_q + 1'b1;
          end
`endif
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_port.sv
// Randomised self-checking bench for wb_master_port. A small Wishbone slave
// with programmable ack latency and word memory sits on the bus; a
// transaction-level reference memory predicts every response.
// Define WB_MASTER_TIMEOUT_EN together with the RTL to exercise the watchdog.
module tb_wb_master_port;

  localparam int unsigned TimeoutCycles = 8;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  wishbone_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb ();

  wb_master_port #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_error(resp_error),
    .wishbone  (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 1) ? 32'h0000_DEAD : 32'h1000_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  // ---------------- bus slave ----------------
  logic        slv_ack;
  logic        stray_ack;
  logic        slv_en;
  int          slv_lat;
  int          slv_wait;
  logic [31:0] slv_mem [64];

  assign wb.ack = slv_ack | stray_ack;

  // Acks slv_lat edges after first seeing strobe; memory indexed by address[7:2].
  always @(posedge clk) begin
    if (!reset) begin
      slv_ack     <= 1'b0;
      slv_wait    <= 0;
      wb.data_out <= '0;
      for (int i = 0; i < 64; i++) slv_mem[i] <= init_word(i);
    end else if (wb.cycle && wb.strobe && slv_en && !slv_ack) begin
      if (slv_wait >= slv_lat) begin
        slv_ack  <= 1'b1;
        slv_wait <= 0;
        if (wb.write_enable) slv_mem[wb.address[7:2]] <= wb.data_in;
        else wb.data_out <= slv_mem[wb.address[7:2]];
      end else begin
        slv_wait <= slv_wait + 1;
      end
    end else begin
      slv_ack <= 1'b0;
      if (!(wb.cycle && wb.strobe)) slv_wait <= 0;
    end
  end

  // ---------------- bus monitor ----------------
  int          cyc_total = 0;
  int          unstable_total = 0;
  logic        prev_cyc = 1'b0;
  logic [31:0] mon_addr;
  logic [31:0] mon_data;
  logic        mon_we;

  // Counts cycles with cycle/strobe up and flags any change of the bus request mid-cycle.
  always @(negedge clk) begin
    if (wb.cycle === 1'b1 || wb.strobe === 1'b1) begin
      cyc_total <= cyc_total + 1;
      if ((wb.cycle !== wb.strobe) ||
          (prev_cyc && (wb.address !== mon_addr || wb.data_in !== mon_data ||
                        wb.write_enable !== mon_we)))
        unstable_total <= unstable_total + 1;
      mon_addr <= wb.address;
      mon_data <= wb.data_in;
      mon_we   <= wb.write_enable;
    end
    prev_cyc <= (wb.cycle === 1'b1);
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [64];

  task automatic model_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
  endtask

  // One complete transaction: issue, await response, hold it `hold` cycles, release.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat, input int hold);
    logic [31:0] exp_rdata;
    logic [31:0] rd;
    logic        er;
    bit          mis;
    int          exp_wait;
    int          waited;
    int          c0;
    int          u0;
    int          bad;
    mis = (addr[1:0] != 2'b00);
    if (mis) begin
      exp_rdata = '0;
      exp_wait  = 1;
    end else begin
      // Ack edge is lat edges after strobe is first seen; response one edge after ack.
      exp_wait = lat + 3;
      if (wr) begin
        ref_mem[addr[7:2]] = wdata;
        exp_rdata          = '0;
      end else begin
        exp_rdata = ref_mem[addr[7:2]];
      end
    end
    slv_lat = lat;
    @(negedge clk);
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    c0        = cyc_total;
    u0        = unstable_total;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    check("req_ready_busy", 32'(req_ready), 32'd0);
    waited = 1;
    while (!resp_valid && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("resp_latency", 32'(waited), 32'(exp_wait));
    rd = resp_rdata;
    er = resp_error;
    check("resp_rdata", rd, exp_rdata);
    check("resp_error", 32'(er), 32'(mis));
    check("bus_cycles", 32'(cyc_total - c0), mis ? 32'd0 : 32'(lat + 2));
    check("bus_stable", 32'(unstable_total - u0), 32'd0);
    if (!mis) begin
      check("bus_addr", mon_addr, {addr[31:2], 2'b00});
      check("bus_we", 32'(mon_we), 32'(wr));
      if (wr) check("bus_wdata", mon_data, wdata);
    end
    if (hold > 0) begin
      bad = 0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_error !== er || req_ready !== 1'b0)
          bad++;
      end
      check("resp_hold", 32'(bad), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_released", 32'(resp_valid), 32'd0);
    check("ready_after", 32'(req_ready), 32'd1);
  endtask

  // Issue a request to a slave that will not ack.
  task automatic start_noack(input logic [31:0] addr);
    slv_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    req_wdata = '0;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    int waited;
    int bad;
    bit wr;
    logic [31:0] a;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    stray_ack  = 1'b0;
    slv_en     = 1'b1;
    slv_lat    = 0;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_req_ready_low", 32'(req_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_cycle", 32'(wb.cycle), 32'd0);
    check("rst_strobe", 32'(wb.strobe), 32'd0);
    check("rst_we", 32'(wb.write_enable), 32'd0);
    check("rst_address", wb.address, 32'd0);
    check("rst_data_in", wb.data_in, 32'd0);

    // Directed: read, write, misaligned, backpressure.
    do_txn(1'b0, 32'h0000_0004, 32'h0, 2, 0);
    do_txn(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 1, 0);
    check("slave_mem_written", slv_mem[4], 32'hCAFE_F00D);
    do_txn(1'b0, 32'h0000_0010, 32'h0, 0, 0);
    do_txn(1'b0, 32'h0000_0006, 32'h0, 0, 0);
    do_txn(1'b0, 32'h0000_0004, 32'h0, 1, 5);

    // Stray ack in IDLE is ignored.
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    check("stray_idle_resp", 32'(resp_valid), 32'd0);
    check("stray_idle_cycle", 32'(wb.cycle), 32'd0);
    check("stray_idle_ready", 32'(req_ready), 32'd1);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      a  = $urandom;
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      else a[1:0] = 2'b00;
      do_txn(wr, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 4));
    end

`ifdef WB_MASTER_TIMEOUT_EN
    // Ack arriving on the expiry edge still completes normally.
    do_txn(1'b0, 32'h0000_0004, 32'h0, 6, 0);
    // Watchdog expiry.
    start_noack(32'h0000_0020);
    waited = 1;
    while (!resp_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("timeout_latency", 32'(waited), 32'(TimeoutCycles + 1));
    check("timeout_error", 32'(resp_error), 32'd1);
    check("timeout_rdata", resp_rdata, 32'd0);
    check("timeout_strobe", 32'(wb.strobe), 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    start_noack(32'h0000_0024);
    repeat (3) @(negedge clk);
`else
    // No watchdog: strobe held indefinitely.
    start_noack(32'h0000_0020);
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (wb.strobe !== 1'b1 || wb.cycle !== 1'b1 || resp_valid !== 1'b0) bad++;
    end
    check("noack_hold", 32'(bad), 32'd0);
`endif

    // Reset in the middle of a bus cycle aborts it with no response.
    check("stb_before_reset", 32'(wb.strobe), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_cycle", 32'(wb.cycle), 32'd0);
    check("abort_strobe", 32'(wb.strobe), 32'd0);
    check("abort_resp", 32'(resp_valid), 32'd0);
    reset  = 1'b1;
    slv_en = 1'b1;
    model_reset();
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || wb.cycle !== 1'b0) bad++;
    end
    check("late_ack_ignored", 32'(bad), 32'd0);
    do_txn(1'b0, 32'h0000_0004, 32'h0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
